// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry-adder operand sequencer: default sizes,
// FSM state encoding and the result-entry layout {ovf, cout, sum}.
package rca_pkg;
    localparam int RCA_WIDTH      = 16;
    localparam int RCA_ADD_LAT    = 4;
    localparam int RCA_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rca_state_e;

    typedef struct packed {
        logic                 ovf;
        logic                 cout;
        logic [RCA_WIDTH-1:0] sum;
    } rca_entry_t;

    localparam int RCA_ENTRY_W = $bits(rca_entry_t);
endpackage

// File: rtl/rca_result_fifo.sv
// First-word fall-through result buffer; DEPTH must be a power of two so the
// pointers wrap naturally.
module rca_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage is reset too so the head reads as zero while in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rca_op_sequencer.sv
// Operand sequencer around a clocked ripple-carry adder: holds operands for ADD_LAT
// cycles, then buffers {ovf, cout, sum}. Define RCA_SEQ_CHECK_EN for the sticky self-check.
module rca_op_sequencer
    import rca_pkg::*;
#(
    parameter int WIDTH      = RCA_WIDTH,
    parameter int ADD_LAT    = RCA_ADD_LAT,
    parameter int FIFO_DEPTH = RCA_FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy,
    output logic             chk_err
);
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam int EW = WIDTH + 2;

    rca_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
    logic              add_cin_q, add_cin_d;
    logic              live_q, live_d;
    logic              chk_err_q, chk_err_d;
    logic              done, ovf, fifo_full, fifo_empty;
    logic [EW-1:0]     head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // live_q keeps in_ready low while reset is asserted and for the release cycle.
    assign in_ready = live_q && (state_q == IDLE) &&
                      (fifo_count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign done     = (state_q == HOLD) && (cnt_q == '0);
    assign ovf      = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) && (add_s[WIDTH-1] != add_a_q[WIDTH-1]);
    assign busy     = (state_q == HOLD);

`ifdef RCA_SEQ_CHECK_EN
    logic [WIDTH:0] ref_sum;
    assign ref_sum = {1'b0, add_a_q} + {1'b0, add_b_q} + {{WIDTH{1'b0}}, add_cin_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        live_d    = 1'b1;
`ifdef RCA_SEQ_CHECK_EN
        chk_err_d = chk_err_q | (done && (ref_sum != {add_cout, add_s}));
`else
        chk_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                state_d   = HOLD;
                cnt_d     = CW'(ADD_LAT - 1);
                add_a_d   = in_a;
                add_b_d   = in_b;
                add_cin_d = in_cin;
            end
            HOLD: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                  else             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            live_q    <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            live_q    <= live_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign chk_err = chk_err_q;

    rca_result_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (done && !fifo_full),
        .push_data ({ovf, add_cout, add_s}),
        .pop       (out_valid && out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign {out_ovf, out_cout, out_sum} = head;
endmodule

// File: tb/tb_rca_op_sequencer.sv
// Bench for rca_op_sequencer with a behavioural adder: directed vectors, corner
// sequences (backpressure, reset mid-hold, self-check) and a randomized scoreboard run.
module tb_rca_op_sequencer;
    logic        CLK, RST_N;
    logic        in_valid, in_ready, in_cin;
    logic [15:0] in_a, in_b, add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        out_valid, out_ready, out_cout, out_ovf, busy, chk_err;
    logic [15:0] out_sum;
    logic        flip;
    logic [16:0] rsum;

    int total = 0;
    int bad   = 0;

    rca_op_sequencer #(.WIDTH(16), .ADD_LAT(4), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy), .chk_err(chk_err)
    );

    // Stand-in for the ripple-carry adder; flip corrupts sum bit 0.
    assign rsum     = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
    assign add_s    = rsum[15:0] ^ {15'b0, flip};
    assign add_cout = rsum[16];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, b, input logic c);
        logic [16:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {16'b0, c};
        v = (a[15] == b[15]) && (s[15] != a[15]);
        return {v, s};
    endfunction

    task automatic send(input logic [15:0] a, b, input logic c);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge CLK); n++; end
        chk("accept_timeout", 32'(n < 50), 1);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    // Called the negedge after the accept edge; returns edges until out_valid.
    task automatic wait_result(output int lat, output int busyc);
        lat = 0; busyc = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busyc++;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin @(negedge CLK); n++; end
        chk("idle_timeout", 32'(n < 50), 1);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [17:0] expq[$];
        logic [17:0] e, inflight;
        int          lat, busyc, rem;
        logic        acc, pp, exp_rdy, exp_chk;

        RST_N = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b0; flip = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        // 1. reset state and release
        @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_chk_err", 32'(chk_err), 0);
        chk("rst_out_sum", 32'({out_ovf, out_cout, out_sum}), 0);
        RST_N = 1'b1;
        #1 chk("release_in_ready_low", 32'(in_ready), 0);
        @(negedge CLK);
        chk("release_in_ready", 32'(in_ready), 1);

        // 2/3. directed vectors
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_result(lat, busyc);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 4);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(busyc), 4);
            chk($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(out_cout), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
            pop_one();
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
        end

        // 4. backpressure: fill the FIFO, fifth op waits for a pop
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            send(16'h0100 * 16'(i + 1), 16'h0011 * 16'(i + 1), 1'(i));
            expq.push_back(model(16'h0100 * 16'(i + 1), 16'h0011 * 16'(i + 1), 1'(i)));
            wait_idle();
        end
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_out_valid", 32'(out_valid), 1);
        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b1;
        expq.push_back(model(16'hABCD, 16'h1111, 1'b1));
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("full_blocks", 32'({in_ready, busy}), 0);
        end
        e = expq.pop_front();
        chk("full_head0", 32'({out_ovf, out_cout, out_sum}), 32'(e));
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("after_pop_in_ready", 32'(in_ready), 1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("fifth_accepted", 32'(busy), 1);
        wait_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = expq.pop_front();
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("drain%0d_data", i), 32'({out_ovf, out_cout, out_sum}), 32'(e));
            @(negedge CLK);
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 0);

        // 5. reset two cycles into HOLD drops the operation
        send(16'h00FF, 16'h0001, 1'b0);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_add_a", 32'(add_a), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("midrst_no_result", 32'({out_valid, busy}), 0);
        end

        // 6. corrupted adder sum bit 0
`ifdef RCA_SEQ_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        flip = 1'b1;
        send(16'h2222, 16'h1111, 1'b0);
        wait_result(lat, busyc);
        flip = 1'b0;
        chk("flip_sum_pushed", 32'(out_sum), 32'h3332);
        chk("flip_chk_err", 32'(chk_err), 32'(exp_chk));
        pop_one();
        send(16'h0001, 16'h0002, 1'b0);
        wait_result(lat, busyc);
        chk("flip_chk_sticky", 32'(chk_err), 32'(exp_chk));
        chk("after_flip_sum", 32'(out_sum), 32'h0003);
        pop_one();

        // randomized run against a queue-based model
        do_reset();
        @(negedge CLK);
        expq.delete();
        rem = 0;
        inflight = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_rdy = (rem == 0) && (expq.size() < 4);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(out_valid), 32'(expq.size() > 0));
            chk("rnd_busy", 32'(busy), 32'(rem > 0));
            if (expq.size() > 0)
                chk("rnd_head", 32'({out_ovf, out_cout, out_sum}), 32'(expq[0]));
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = (cyc < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            acc = in_valid && exp_rdy;
            pp  = out_ready && (expq.size() > 0);
            if (pp) void'(expq.pop_front());
            if (rem > 0) begin
                rem--;
                if (rem == 0) expq.push_back(inflight);
            end
            if (acc) begin
                rem = 4;
                inflight = model(in_a, in_b, in_cin);
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
